signed_square_accum: RTL

//  Pipelined, parametrised signed squarer plus power integrator. Each clock it squares

---
 rtl/signed_square_accum.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/signed_square_accum.sv
// Pipelined signed squarer and windowed power integrator: NLANE samples squared, summed
// and accumulated over ACC_LEN valid beats. Define SIGNED_SQUARE_ACC_SATURATE_EN for a clamping accumulator.
module signed_square_accum #(
  parameter int WIDTH     = 8,
  parameter int NLANE     = 4,
  parameter int ACC_LEN   = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NLANE*WIDTH-1:0] dat_i,
  input  logic                   valid_i,
  input  logic                   clear_i,
  output logic [ACC_WIDTH-1:0]   pow_o,
  output logic                   pow_valid_o,
  output logic                   sat_o
);

  localparam int SQ_W   = 2*WIDTH - 1;
  localparam int HI_W   = 2*WIDTH - 3;
  localparam int SUM_W  = SQ_W + $clog2(NLANE);
  localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // With m = 2a + b, m*m = 4*a*(a+b) + b: bit 1 is always 0 and bit 0 is b,
  // so only a*(a+b) needs a multiplier, two bits narrower than a full square.
  function automatic logic [HI_W-1:0] square_hi(input logic [WIDTH-1:0] m);
    logic [HI_W-1:0] a;
    logic [HI_W-1:0] ab;
    a  = HI_W'(m[WIDTH-1:1]);
    ab = a + HI_W'(m[0]);
    return a * ab;
  endfunction

  // ---------------- input register ----------------
  logic [NLANE*WIDTH-1:0] s0_dat;
  logic                   s0_valid;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  // NOTE: data registers are reset too, so nothing stale can surface after a mid-window reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s0_dat   <= '0;
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= valid_i & ~clear_i;
      if (valid_i) s0_dat <= dat_i;
    end
  end

  // ---------------- S1: per-lane square ----------------
  logic [HI_W-1:0]  sq_hi_d [NLANE];
  logic [NLANE-1:0] sq_lsb_d;
  logic [HI_W-1:0]  s1_hi   [NLANE];
  logic [NLANE-1:0] s1_lsb;
  logic             s1_valid;

  always_comb begin
    for (int k = 0; k < NLANE; k++) begin
      sq_hi_d[k]  = square_hi(magnitude(s0_dat[k*WIDTH +: WIDTH]));
      sq_lsb_d[k] = s0_dat[k*WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NLANE; k++) s1_hi[k] <= '0;
      s1_lsb   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s0_valid & ~clear_i;
      if (s0_valid) begin
        s1_hi  <= sq_hi_d;
        s1_lsb <= sq_lsb_d;
      end
    end
  end

  // ---------------- S2: lane sum ----------------
  logic [SUM_W-1:0] sum_d;
  logic [SUM_W-1:0] s2_sum;
  logic             s2_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NLANE; k++) begin
      sum_d = sum_d + SUM_W'({s1_hi[k], 1'b0, s1_lsb[k]});
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_sum   <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid & ~clear_i;
      if (s1_valid) s2_sum <= sum_d;
    end
  end

  // ---------------- S3: window accumulator ----------------
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]     cnt;
  logic                 window_end;

  assign window_end = s2_valid && (cnt == CNT_LAST);

`ifdef SIGNED_SQUARE_ACC_SATURATE_EN
  localparam int ACC_W1 = ACC_WIDTH + 1;
  logic [ACC_WIDTH:0] acc_wide;
  logic               sat_flag;
  logic               sat_hit;

  always_comb begin
    acc_wide = {1'b0, acc} + ACC_W1'(s2_sum);
    sat_hit  = sat_flag | acc_wide[ACC_WIDTH];
    acc_next = sat_hit ? '1 : acc_wide[ACC_WIDTH-1:0];
  end

  // Sticky flag lives for one window; sat_o is published alongside the strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_flag <= 1'b0;
      sat_o    <= 1'b0;
    end else if (clear_i) begin
      sat_flag <= 1'b0;
    end else if (window_end) begin
      sat_o    <= sat_hit;
      sat_flag <= 1'b0;
    end else if (s2_valid) begin
      sat_flag <= sat_hit;
    end
  end
`else
  always_comb begin
    acc_next = acc + ACC_WIDTH'(s2_sum);
  end

  assign sat_o = 1'b0;
`endif

  // Clear aborts the window silently: no strobe, pow_o keeps its last value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc         <= '0;
      cnt         <= '0;
      pow_o       <= '0;
      pow_valid_o <= 1'b0;
    end else begin
      pow_valid_o <= 1'b0;
      if (clear_i) begin
        acc <= '0;
        cnt <= '0;
      end else if (window_end) begin
        pow_o       <= acc_next;
        pow_valid_o <= 1'b1;
        acc         <= '0;
        cnt         <= '0;
      end else if (s2_valid) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
